// File: rtl/ro_meas_counter.sv
// Ring-oscillator channel mux with synchronised pad output and gated rising-edge
// frequency counter (single-shot or continuous).
module ro_meas_counter #(
   parameter int N_CH   = 16,
   parameter int SEL_W  = $clog2(N_CH),
   parameter int GATE_W = 16,
   parameter int CNT_W  = 24,
   parameter int SETTLE = 4
) (
   input  logic              wb_clk_i,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   ro_in,
   input  logic [SEL_W-1:0]  sel,
   input  logic [GATE_W-1:0] gate_cycles,
   input  logic              cont,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              ro_out
);

   // state    | meaning
   // S_IDLE   | waiting for start, config may change freely
   // S_SETTLE | flushing synchroniser after channel switch
   // S_GATE   | counting rising edges for gate_q cycles
   // S_DONE   | dead cycle, result is published at the following edge
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_GATE, S_DONE} state_t;

   localparam logic [GATE_W-1:0] SETTLE_LD = GATE_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0]  ACC_MAX   = {CNT_W{1'b1}};

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [GATE_W-1:0] gate_q, gate_d;
   logic              cont_q, cont_d;
   logic [GATE_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0]  acc_q, acc_d;
   logic              acc_ovf_q, acc_ovf_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;
   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   logic              prev_q, prev_d;
   logic              ro_sel;
   logic              rise;

   always_comb begin
      ro_sel = ro_in[0];
      if (int'(sel_q) < N_CH) ro_sel = ro_in[sel_q];
      sync1_d = ro_sel;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   assign rise = sync2_q & ~prev_q;

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      gate_d    = gate_q;
      cont_d    = cont_q;
      tmr_d     = tmr_q;
      acc_d     = acc_q;
      acc_ovf_d = acc_ovf_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  sel_d   = sel;
                  gate_d  = gate_cycles;
                  cont_d  = cont;
                  tmr_d   = SETTLE_LD;
                  state_d = S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (tmr_q == '0) begin
                  acc_d     = '0;
                  acc_ovf_d = 1'b0;
                  tmr_d     = gate_q - GATE_W'(1);
                  state_d   = (gate_q == '0) ? S_DONE : S_GATE;
               end else begin
                  tmr_d = tmr_q - GATE_W'(1);
               end
            end
            S_GATE: begin
               if (rise) begin
                  if (acc_q == ACC_MAX) acc_ovf_d = 1'b1;
                  else                  acc_d     = acc_q + CNT_W'(1);
               end
               if (tmr_q == '0) state_d = S_DONE;
               else             tmr_d   = tmr_q - GATE_W'(1);
            end
            S_DONE: begin
               count_d = acc_q;
               ovf_d   = acc_ovf_q;
               done_d  = 1'b1;
               if (cont_q) begin
                  acc_d     = '0;
                  acc_ovf_d = 1'b0;
                  tmr_d     = gate_q - GATE_W'(1);
                  state_d   = (gate_q == '0) ? S_DONE : S_GATE;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sel_q     <= '0;
         gate_q    <= '0;
         cont_q    <= 1'b0;
         tmr_q     <= '0;
         acc_q     <= '0;
         acc_ovf_q <= 1'b0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         prev_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         gate_q    <= gate_d;
         cont_q    <= cont_d;
         tmr_q     <= tmr_d;
         acc_q     <= acc_d;
         acc_ovf_q <= acc_ovf_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         prev_q    <= prev_d;
      end
   end

   // The published pulse trails the DONE state by one edge, so busy covers it.
   assign busy     = (state_q != S_IDLE) | done_q;
   assign done     = done_q;
   assign count    = count_q;
   assign overflow = ovf_q;
   assign ro_out   = sync2_q;

endmodule
